mips_single_cycle_core: RTL and testbench
=========================================

// Module: mips_single_cycle_core
// PURPOSE
//  Single-cycle 32-bit MIPS-subset CPU core: one instruction fetched, executed and retired per clk.
//  Sits between an external instruction ROM (driven by pc, returns instr) and a data RAM (memwrite/dataadr/writedata -> readdata).
//  Adds a debug tap: a 5-bit switch input selects a register-file entry, driven combinationally on dispDat.
// PARAMETERS
//  RESET_PC  32'h0000_0000  pc value loaded by reset
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  pc         out  32  current instruction address (to instruction memory)
//  instr      in   32  instruction word at pc (combinational from memory)
//  memwrite   out  1   data-memory write enable for this cycle
//  dataadr    out  32  data-memory byte address (ALU result)
//  writedata  out  32  store data (rt register value)
//  readdata   in   32  load data from data memory (combinational read)
//  switches   in   5   debug register-select index
//  dispDat    out  32  debug view: regfile[switches]
// BEHAVIOUR
//  Reset: on posedge clk with reset=1, pc<=RESET_PC and all 32 registers <= 0.
//   memwrite is forced 0 while reset=1. dispDat reads 0 after reset.
//  Only pc and the register file are state. All other outputs are combinational from pc/instr/registers/readdata.
//  Supported instructions (opcode/funct in hex):
//   - R-type (op 00): add 20, sub 22, and 24, or 25, slt 2A, jr 08.
//   - I/J-type: lw 23, sw 2B, beq 04, addi 08, j 02, jal 03.
//  Arithmetic:
//   - 32-bit two's complement; overflow ignored, no traps.
//   - slt is a signed compare that writes 1 or 0.
//   - Immediates are sign-extended.
//  Memory: lw/sw address = rs + signext(imm). lw writes readdata to rt. sw drives memwrite=1, writedata=rt.
//  Next pc:
//   - beq taken: pc+4 + (signext(imm)<<2).
//   - j/jal: {pc+4[31:28], instr[25:0], 2'b00}.
//   - jr: rs.
//   - Otherwise: pc+4.
//  Register writeback:
//   - Write-back on posedge clk. R-type writes rd; addi and lw write rt; jal writes pc+4 to $31.
//   - Writes to $0 are discarded; $0 always reads 0.
//  Unknown opcode/funct: treated as nop (no register write, memwrite=0, pc+4).
//  Regfile reads are combinational. A value written at an edge is visible on rs/rt/dispDat immediately after that edge.
//  dispDat = regfile[switches] combinationally; switches=0 -> 0.
//  Reset mid-program: the next posedge restarts at RESET_PC with cleared registers. Memory contents are untouched.
//  dataadr is the ALU result for every instruction, not only lw/sw. It is don't-care when memwrite=0 and the op is not lw.
// STRUCTURE
//  Shared package mips_pkg: opcode/funct localparams, ALU-control encoding (AND, OR, ADD, SUB, SLT), control-word struct/typedef.
//  Sub-module mips_regfile: 32x32 registers, 3 combinational read ports (rs, rt, debug), 1 sync write port, $0 hardwired zero.
//  The core holds the main decoder + ALU decoder, ALU, sign-extend, and pc/next-pc logic.
// TESTING
//  Bench uses a 64-word instr ROM indexed by pc[7:2], and a 64-word sync-write / async-read data RAM indexed by dataadr[7:2].
//  Scenarios:
//  1. Reset held 1 cycle: pc=0, memwrite=0; for every switches value 0..31, dispDat=0.
//  2. Run addi $2,$0,5 then addi $3,$0,12: after 2 edges, switches=2 -> dispDat=5 and switches=3 -> dispDat=12.
//  3. ALU ops with $2=5, $3=12:
//     - sub $4,$3,$2 -> 7;  or $5,$2,$3 -> 13;  and $6,$2,$3 -> 4.
//     - slt $7,$2,$3 -> 1;  slt with $2=-1, $3=1 -> 1 (signed).
//  4. Store/load:
//     - sw $4,84($0) with $4=7: in that cycle memwrite=1, dataadr=84, writedata=7.
//     - Next cycle lw $8,84($0) -> $8=7.
//  5. Control flow:
//     - beq with equal regs at pc=0x10, imm=2 -> pc=0x1C; unequal regs -> pc=0x14.
//     - j 0x0000011 -> pc=0x44.
//     - jal at pc=0x20 -> $31=0x24, then jr $31 -> pc=0x24.
//  6. Mid-run reset: assert reset one cycle at pc=0x30 -> pc=0, registers 0.
//     Writes to $0 (addi $0,$0,9) leave dispDat(switches=0)=0.
//     Undefined opcode 0x3F -> pc+4 only.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU-control codes and the decoded control word
// for the single-cycle MIPS-subset core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    regwrite;
        logic    regdst;     // 1: write rd, 0: write rt
        logic    alusrc;     // 1: ALU B operand is the sign-extended immediate
        logic    branch;
        logic    memwrite;
        logic    memtoreg;
        logic    jump;
        logic    link;       // jal: write pc+4 into $31
        logic    jumpreg;    // jr: next pc comes from rs
        alu_op_e alu;
    } ctrl_t;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: three combinational read ports (rs, rt, debug) and one
// synchronous write port; register $0 always reads zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  ra3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
    assign rd3 = (ra3 == 5'd0) ? '0 : regs[ra3];

endmodule

// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS-subset core: decode, ALU, next-pc and write-back all resolve
// within one clk; only pc and the register file hold state.
module mips_single_cycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic [4:0]  switches,
    output logic [31:0] dispDat
);

    ctrl_t       ctrl;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] signimm;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] rtval;
    logic [31:0] aluresult;
    logic [31:0] pcplus4;
    logic [31:0] pcbranch;
    logic [31:0] pcjump;
    logic [31:0] pcnext;
    logic [4:0]  wa;
    logic [31:0] wd;

    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign signimm = {{16{instr[15]}}, instr[15:0]};

    // Anything not listed falls through as an all-zero control word, i.e. a nop.
    always_comb begin
        ctrl     = '0;
        ctrl.alu = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alu = ALU_ADD; end
                    FN_SUB: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alu = ALU_SUB; end
                    FN_AND: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alu = ALU_AND; end
                    FN_OR:  begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alu = ALU_OR;  end
                    FN_SLT: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alu = ALU_SLT; end
                    FN_JR:  ctrl.jumpreg = 1'b1;
                    default: ;
                endcase
            end
            OP_LW:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.memtoreg = 1'b1; end
            OP_SW:   begin ctrl.alusrc = 1'b1; ctrl.memwrite = 1'b1; end
            OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.alu = ALU_SUB; end
            OP_ADDI: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; end
            OP_J:    ctrl.jump = 1'b1;
            OP_JAL:  begin ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.regwrite = 1'b1; end
            default: ;
        endcase
    end

    assign srcb = ctrl.alusrc ? signimm : rtval;

    always_comb begin
        case (ctrl.alu)
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_ADD: aluresult = srca + srcb;
            ALU_SUB: aluresult = srca - srcb;
            ALU_SLT: aluresult = ($signed(srca) < $signed(srcb)) ? 32'd1 : 32'd0;
            default: aluresult = '0;
        endcase
    end

    assign pcplus4  = pc + 32'd4;
    assign pcbranch = pcplus4 + (signimm << 2);
    assign pcjump   = {pcplus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        if (ctrl.jumpreg)
            pcnext = srca;
        else if (ctrl.jump)
            pcnext = pcjump;
        else if (ctrl.branch && (aluresult == 32'd0))
            pcnext = pcbranch;
        else
            pcnext = pcplus4;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else
            pc <= pcnext;
    end

    assign wa = ctrl.link ? 5'd31 : (ctrl.regdst ? rd : rt);
    assign wd = ctrl.link ? pcplus4 : (ctrl.memtoreg ? readdata : aluresult);

    mips_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (ctrl.regwrite),
        .wa    (wa),
        .wd    (wd),
        .ra1   (rs),
        .ra2   (rt),
        .ra3   (switches),
        .rd1   (srca),
        .rd2   (rtval),
        .rd3   (dispDat)
    );

    // A store decoded during reset must not reach memory.
    assign memwrite  = ctrl.memwrite & ~reset;
    assign dataadr   = aluresult;
    assign writedata = rtval;

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Self-checking bench: straight-line ALU/memory program driven from a vector
// table, then a hand-written control-flow and mid-run-reset sequence.
module tb_mips_single_cycle_core;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  switches;
    logic [31:0] dispDat;

    logic [31:0] rom [0:63];
    logic [31:0] ram [0:63];

    int n_checks;
    int n_fail;

    mips_single_cycle_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .switches  (switches),
        .dispDat   (dispDat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr    = rom[pc[7:2]];
    assign readdata = ram[dataadr[7:2]];

    always @(posedge clk) begin
        if (memwrite) ram[dataadr[7:2]] <= writedata;
    end

    typedef struct {
        logic [31:0] ins;
        logic        exp_mw;
        logic        chk_mem;
        logic [31:0] exp_adr;
        logic [31:0] exp_wd;
        logic [4:0]  chk_reg;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] o, input logic [25:0] a);
        return {o, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
        switches = r;
        #1;
        check(name, dispDat, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        switches = 5'd0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'h0;
            ram[i] = 32'h0;
        end

        vecs[0]  = '{enc_i(6'h08, 5'd0, 5'd2, 16'd5),      1'b0, 1'b0, 32'd0,  32'd0, 5'd2,  32'd5};
        vecs[1]  = '{enc_i(6'h08, 5'd0, 5'd3, 16'd12),     1'b0, 1'b0, 32'd0,  32'd0, 5'd3,  32'd12};
        vecs[2]  = '{enc_r(6'h22, 5'd3, 5'd2, 5'd4),       1'b0, 1'b0, 32'd0,  32'd0, 5'd4,  32'd7};
        vecs[3]  = '{enc_r(6'h25, 5'd2, 5'd3, 5'd5),       1'b0, 1'b0, 32'd0,  32'd0, 5'd5,  32'd13};
        vecs[4]  = '{enc_r(6'h24, 5'd2, 5'd3, 5'd6),       1'b0, 1'b0, 32'd0,  32'd0, 5'd6,  32'd4};
        vecs[5]  = '{enc_r(6'h2A, 5'd2, 5'd3, 5'd7),       1'b0, 1'b0, 32'd0,  32'd0, 5'd7,  32'd1};
        vecs[6]  = '{enc_r(6'h20, 5'd2, 5'd3, 5'd9),       1'b0, 1'b0, 32'd0,  32'd0, 5'd9,  32'd17};
        vecs[7]  = '{enc_i(6'h2B, 5'd0, 5'd4, 16'd84),     1'b1, 1'b1, 32'd84, 32'd7, 5'd4,  32'd7};
        vecs[8]  = '{enc_i(6'h23, 5'd0, 5'd8, 16'd84),     1'b0, 1'b1, 32'd84, 32'd0, 5'd8,  32'd7};
        vecs[9]  = '{enc_i(6'h08, 5'd0, 5'd10, 16'hFFFF),  1'b0, 1'b0, 32'd0,  32'd0, 5'd10, 32'hFFFF_FFFF};
        vecs[10] = '{enc_i(6'h08, 5'd0, 5'd11, 16'd1),     1'b0, 1'b0, 32'd0,  32'd0, 5'd11, 32'd1};
        vecs[11] = '{enc_r(6'h2A, 5'd10, 5'd11, 5'd12),    1'b0, 1'b0, 32'd0,  32'd0, 5'd12, 32'd1};
        vecs[12] = '{enc_r(6'h2A, 5'd11, 5'd10, 5'd13),    1'b0, 1'b0, 32'd0,  32'd0, 5'd13, 32'd0};
        vecs[13] = '{enc_i(6'h08, 5'd0, 5'd0, 16'd9),      1'b0, 1'b0, 32'd0,  32'd0, 5'd0,  32'd0};
        vecs[14] = '{enc_i(6'h3F, 5'd2, 5'd2, 16'd4),      1'b0, 1'b0, 32'd0,  32'd0, 5'd2,  32'd5};
        vecs[15] = '{enc_r(6'h22, 5'd2, 5'd3, 5'd14),      1'b0, 1'b0, 32'd0,  32'd0, 5'd14, 32'hFFFF_FFF9};
        for (int i = 0; i < 16; i++) rom[i] = vecs[i].ins;

        // reset state
        tick();
        check("reset_pc", pc, 32'h0);
        check("reset_memwrite", {31'd0, memwrite}, 32'd0);
        for (int r = 0; r < 32; r++) begin
            check_reg($sformatf("reset_reg%0d", r), r[4:0], 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            switches = vecs[i].chk_reg;
            #1;
            check($sformatf("v%0d_memwrite", i), {31'd0, memwrite}, {31'd0, vecs[i].exp_mw});
            if (vecs[i].chk_mem) begin
                check($sformatf("v%0d_dataadr", i), dataadr, vecs[i].exp_adr);
                if (vecs[i].exp_mw) check($sformatf("v%0d_writedata", i), writedata, vecs[i].exp_wd);
            end
            tick();
            check($sformatf("v%0d_pc", i), pc, 32'((i + 1) * 4));
            check($sformatf("v%0d_reg", i), dispDat, vecs[i].exp_reg);
        end
        check("ram_word21", ram[21], 32'd7);

        // control flow program, reloaded under reset
        reset = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0]  = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
        rom[1]  = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
        rom[2]  = enc_i(6'h08, 5'd0, 5'd4, 16'd4);
        rom[3]  = enc_i(6'h04, 5'd2, 5'd4, 16'd7);
        rom[4]  = enc_i(6'h04, 5'd2, 5'd3, 16'd2);
        rom[7]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        rom[8]  = enc_j(6'h03, 26'h14);
        rom[20] = enc_r(6'h08, 5'd31, 5'd0, 5'd0);
        rom[9]  = enc_j(6'h02, 26'h11);
        rom[17] = enc_i(6'h08, 5'd0, 5'd5, 16'd7);
        rom[18] = enc_j(6'h02, 26'h0C);
        rom[12] = enc_i(6'h2B, 5'd0, 5'd5, 16'd0);
        tick();
        check("reload_pc", pc, 32'h0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("pre_beq_pc", pc, 32'h0C);
        tick();
        check("beq_not_taken_pc", pc, 32'h10);
        tick();
        check("beq_taken_pc", pc, 32'h1C);
        tick();
        check("addi_pc", pc, 32'h20);
        tick();
        check("jal_pc", pc, 32'h50);
        check_reg("jal_link", 5'd31, 32'h24);
        tick();
        check("jr_pc", pc, 32'h24);
        tick();
        check("j_pc", pc, 32'h44);
        tick();
        check("after_j_pc", pc, 32'h48);
        check_reg("after_j_reg5", 5'd5, 32'd7);
        tick();
        check("j_back_pc", pc, 32'h30);
        check("sw_memwrite_run", {31'd0, memwrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("sw_memwrite_in_reset", {31'd0, memwrite}, 32'd0);
        tick();
        reset = 1'b0;
        check("midreset_pc", pc, 32'h0);
        check_reg("midreset_reg5", 5'd5, 32'd0);
        check_reg("midreset_reg31", 5'd31, 32'd0);
        check("midreset_ram0", ram[0], 32'd0);
        check("midreset_ram21_kept", ram[21], 32'd7);
        tick();
        check("restart_pc", pc, 32'h04);
        check_reg("restart_reg2", 5'd2, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
